// File: rtl/stage4_field_serializer_if.sv
// Stage-4 serializer handshake bundle: header in (valid/ready), word stream out (valid/ready/last), status.
// slave = serializer side, master = stage-3 producer / downstream consumer side.
interface stage4_field_serializer_if #(
  parameter int HDR_BITS = 64,
  parameter int OUT_W    = 8,
  parameter int CNT_W    = 16
);
  logic [HDR_BITS-1:0] hdr_in;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic [CNT_W-1:0]    frame_cnt;

  modport slave (
    input  hdr_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, frame_cnt
  );

  modport master (
    output hdr_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, frame_cnt
  );
endinterface

// File: rtl/stage4_field_serializer.sv
// Holds one header bundle and emits it MSB-first as OUT_W words, first word 1 cycle after capture; outputs hold while
// out_ready is low, in_ready only in IDLE or on last-word accept. STAGE4_XOR_CHECK_EN appends an XOR checksum word.
module stage4_field_serializer #(
  parameter int HDR_BITS = 64,
  parameter int OUT_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  stage4_field_serializer_if.slave  bus
);

  localparam int NW    = (HDR_BITS + OUT_W - 1) / OUT_W;
  localparam int PAD_W = NW * OUT_W;
`ifdef STAGE4_XOR_CHECK_EN
  localparam int NWORDS = NW + 1;
`else
  localparam int NWORDS = NW;
`endif
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
`ifdef STAGE4_XOR_CHECK_EN
  localparam logic [IDX_W-1:0] DATA_LAST_IDX = IDX_W'(NW - 1);
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PAD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef STAGE4_XOR_CHECK_EN
  logic [OUT_W-1:0]    csum_q, csum_d;
`endif

  logic [PAD_W-1:0]    hdr_pad;
  logic                out_xfer;
  logic                in_rdy;
  logic                in_xfer;

  // Left-justify the bundle so padding zeros land in the LSBs of the final word.
  assign hdr_pad  = PAD_W'(bus.hdr_in) << (PAD_W - HDR_BITS);
  assign out_xfer = out_valid_q && bus.out_ready;
  assign in_rdy   = !rst && ((state_q == IDLE) ||
                             ((state_q == SEND) && out_xfer && out_last_q));
  assign in_xfer  = bus.in_valid && in_rdy;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
`ifdef STAGE4_XOR_CHECK_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
      end
      SEND: begin
        if (out_xfer) begin
          if (out_last_q) begin
            cnt_d       = cnt_q + CNT_W'(1);
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            out_last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
            out_data_d = hold_q[PAD_W-1 -: OUT_W];
            hold_d     = hold_q << OUT_W;
`ifdef STAGE4_XOR_CHECK_EN
            csum_d     = csum_q ^ out_data_q;
            if (idx_q == DATA_LAST_IDX) begin
              out_data_d = csum_q ^ out_data_q;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A capture overrides the frame-end path so back-to-back frames have no bubble.
    if (in_xfer) begin
      state_d     = SEND;
      hold_d      = hdr_pad << OUT_W;
      out_data_d  = hdr_pad[PAD_W-1 -: OUT_W];
      idx_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = (LAST_IDX == '0);
`ifdef STAGE4_XOR_CHECK_EN
      csum_d      = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
`ifdef STAGE4_XOR_CHECK_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
`ifdef STAGE4_XOR_CHECK_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == SEND);
  assign bus.frame_cnt = cnt_q;

endmodule
